// File: rtl/npu_pkg.sv
// Shared NPU definitions: the driver FSM state type and the default Perceptron pipeline latency.
// Also provides fallback values for the N and DATA_WIDTH build macros.
`ifndef N
`define N 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package npu_pkg;

    localparam int unsigned PERCEPTRON_LATENCY = 2;

    typedef enum logic [1:0] {
        LOAD,
        WAIT,
        RESULT
    } state_t;

endpackage

// File: rtl/vector_packer.sv
// N-slot x/w element register file with an indexed write port, plus the bias register.
// All contents reset to zero and otherwise hold until rewritten.
module vector_packer
    import npu_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_W      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [DATA_WIDTH-1:0]   i_x,
    input  logic [DATA_WIDTH-1:0]   i_w,
    input  logic                    i_bias_we,
    input  logic [DATA_WIDTH-1:0]   i_bias,
    output logic [N*DATA_WIDTH-1:0] o_x,
    output logic [N*DATA_WIDTH-1:0] o_w,
    output logic [DATA_WIDTH-1:0]   o_b
);

    logic [N*DATA_WIDTH-1:0] r_x;
    logic [N*DATA_WIDTH-1:0] r_w;
    logic [DATA_WIDTH-1:0]   r_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_w <= '0;
            r_b <= '0;
        end else begin
            // Loop decode keeps out-of-range indices (non power-of-two N) harmless.
            for (int i = 0; i < int'(N); i++) begin
                if (i_we && (int'(i_idx) == i)) begin
                    r_x[i*DATA_WIDTH +: DATA_WIDTH] <= i_x;
                    r_w[i*DATA_WIDTH +: DATA_WIDTH] <= i_w;
                end
            end
            if (i_bias_we) begin
                r_b <= i_bias;
            end
        end
    end

    assign o_x = r_x;
    assign o_w = r_w;
    assign o_b = r_b;

endmodule

// File: rtl/perceptron_driver.sv
// Streaming front end for one Perceptron: packs x/w (and bias) beats, waits out the pipeline,
// returns y on a valid/ready port. Define PERCEPTRON_DRIVER_BIAS_EN for a leading bias beat.
`ifndef N
`define N 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module perceptron_driver
    import npu_pkg::*;
#(
    parameter int unsigned N          = `N,
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned LATENCY    = PERCEPTRON_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_x,
    input  logic [DATA_WIDTH-1:0]   in_w,
    input  logic                    in_last,
    output logic [N*DATA_WIDTH-1:0] x_o,
    output logic [N*DATA_WIDTH-1:0] w_o,
    output logic [DATA_WIDTH-1:0]   b_o,
    input  logic [DATA_WIDTH-1:0]   y_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_y,
    output logic                    err_len
);

`ifdef PERCEPTRON_DRIVER_BIAS_EN
    localparam bit BiasEn = 1'b1;
`else
    localparam bit BiasEn = 1'b0;
`endif

    localparam int unsigned CntW      = $clog2(N + 1);
    localparam int unsigned WcntW     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int unsigned IdxW      = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned FirstElem = BiasEn ? 1 : 0;
    localparam logic [CntW-1:0]  LastCnt = CntW'(N - 1 + FirstElem);
    localparam logic [WcntW-1:0] WaitEnd = WcntW'(LATENCY);

    state_t                r_state, w_state_nxt;
    logic [CntW-1:0]       r_cnt, w_cnt_nxt;
    logic [WcntW-1:0]      r_wcnt, w_wcnt_nxt;
    logic                  r_out_valid, w_out_valid_nxt;
    logic [DATA_WIDTH-1:0] r_out_y, w_out_y_nxt;
    logic                  r_err, w_err_nxt;
    logic                  w_we;
    logic                  w_bias_we;
    logic [IdxW-1:0]       w_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_wcnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_y     <= w_out_y_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_wcnt_nxt      = r_wcnt;
        w_out_valid_nxt = r_out_valid;
        w_out_y_nxt     = r_out_y;
        w_err_nxt       = 1'b0;
        w_we            = 1'b0;
        w_bias_we       = 1'b0;
        // Element slot is the beat count minus the leading bias beat, if any.
        w_idx           = IdxW'(r_cnt - CntW'(FirstElem));
        unique case (r_state)
            LOAD: begin
                if (in_valid) begin
                    if (BiasEn && (r_cnt == '0)) begin
                        if (in_last) begin
                            w_err_nxt = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_bias_we = 1'b1;
                            w_cnt_nxt = CntW'(1);
                        end
                    end else begin
                        w_we = 1'b1;
                        if (r_cnt == LastCnt) begin
                            w_cnt_nxt = '0;
                            if (in_last) begin
                                w_state_nxt = WAIT;
                                w_wcnt_nxt  = '0;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end else if (in_last) begin
                            w_err_nxt = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CntW'(1);
                        end
                    end
                end
            end
            WAIT: begin
                if (r_wcnt == WaitEnd) begin
                    w_out_y_nxt     = y_i;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = RESULT;
                end else begin
                    w_wcnt_nxt = r_wcnt + WcntW'(1);
                end
            end
            RESULT: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = LOAD;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    vector_packer #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IdxW)
    ) u_vector_packer (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_idx     (w_idx),
        .i_x       (in_x),
        .i_w       (in_w),
        .i_bias_we (w_bias_we),
        .i_bias    (in_x),
        .o_x       (x_o),
        .o_w       (w_o),
        .o_b       (b_o)
    );

    assign in_ready  = (r_state == LOAD);
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign err_len   = r_err;

endmodule

// File: tb/tb_perceptron_driver.sv
// Self-checking bench for perceptron_driver: directed corner sequences plus a table of
// random vectors checked against a dot-product/ReLU reference and a 2-stage Perceptron stub.
`ifndef N
`define N 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_perceptron_driver;

    localparam int NN  = `N;
    localparam int DW  = `DATA_WIDTH;
    localparam int NRV = 8;

    typedef struct packed {
        logic [NN-1:0][DW-1:0] x;
        logic [NN-1:0][DW-1:0] w;
        logic [DW-1:0]         b;
        logic [DW-1:0]         y;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DW-1:0]        in_x = '0;
    logic [DW-1:0]        in_w = '0;
    logic                 in_last = 1'b0;
    logic [NN*DW-1:0]     x_o;
    logic [NN*DW-1:0]     w_o;
    logic [DW-1:0]        b_o;
    logic [DW-1:0]        y_i;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [DW-1:0]        out_y;
    logic                 err_len;

    int checks   = 0;
    int failures = 0;

    logic          stub_force = 1'b0;
    logic [DW-1:0] stub_s1 = '0;
    logic [DW-1:0] stub_s2 = '0;

    always #5 clk = ~clk;

    perceptron_driver dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .x_o       (x_o),
        .w_o       (w_o),
        .b_o       (b_o),
        .y_i       (y_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .err_len   (err_len)
    );

    // Reference Perceptron: signed dot product plus bias, ReLU, truncated to DW bits.
    function automatic logic [DW-1:0] perceptron_ref(input logic [NN-1:0][DW-1:0] x,
                                                     input logic [NN-1:0][DW-1:0] w,
                                                     input logic [DW-1:0] b);
        longint acc;
        acc = longint'($signed(b));
        for (int i = 0; i < NN; i++) begin
            acc += longint'($signed(x[i])) * longint'($signed(w[i]));
        end
        if (acc < 0) acc = 0;
        return DW'(acc);
    endfunction

    // Two-stage Perceptron stand-in fed from the driver's packed outputs.
    always @(posedge clk) begin
        stub_s1 <= stub_force ? DW'(8'h2A) : perceptron_ref(x_o, w_o, b_o);
        stub_s2 <= stub_s1;
    end
    assign y_i = stub_s2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [DW-1:0] x, input logic [DW-1:0] w, input logic last);
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load_vec(input vec_t v);
`ifdef PERCEPTRON_DRIVER_BIAS_EN
        beat(v.b, DW'(0), 1'b0);
`endif
        for (int i = 0; i < NN; i++) begin
            beat(v.x[i], v.w[i], i == NN - 1);
        end
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int hold;
        logic dropped;
        load_vec(v);
        check({tag, "_x_o"}, x_o, v.x);
        check({tag, "_w_o"}, w_o, v.w);
        check({tag, "_b_o"}, b_o, v.b);
        check({tag, "_in_ready_wait"}, in_ready, 1'b0);
        wait_result(n);
        check({tag, "_latency"}, n, 3);
        check({tag, "_out_y"}, out_y, v.y);
        hold = $urandom_range(0, 3);
        dropped = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (!out_valid) dropped = 1'b1;
        end
        check({tag, "_valid_hold"}, dropped, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_clear"}, out_valid, 1'b0);
        check({tag, "_in_ready_back"}, in_ready, 1'b1);
    endtask

    function automatic vec_t mk_vec(input logic [NN-1:0][DW-1:0] x,
                                    input logic [NN-1:0][DW-1:0] w,
                                    input logic [DW-1:0] b);
        vec_t v;
        v.x = x;
        v.w = w;
        v.b = b;
        v.y = perceptron_ref(x, w, b);
        return v;
    endfunction

    initial begin
        vec_t tab[NRV];
        vec_t basic;
        logic [NN-1:0][DW-1:0] rx;
        logic [NN-1:0][DW-1:0] rw;
        logic [DW-1:0] rb;
        int n;
        int pulses;
        logic seen;

        for (int i = 0; i < NN; i++) begin
            rx[i] = DW'(i + 1);
            rw[i] = DW'(i + 5);
        end
`ifdef PERCEPTRON_DRIVER_BIAS_EN
        rb = DW'(-3);
`else
        rb = '0;
`endif
        basic = mk_vec(rx, rw, rb);
        tab[0] = basic;
        for (int k = 1; k < NRV; k++) begin
            for (int i = 0; i < NN; i++) begin
                rx[i] = DW'($urandom);
                rw[i] = DW'($urandom);
            end
`ifdef PERCEPTRON_DRIVER_BIAS_EN
            rb = DW'($urandom);
`endif
            tab[k] = mk_vec(rx, rw, rb);
        end

        // Reset values while held in reset.
        step();
        step();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_err_len", err_len, 1'b0);
        check("rst_x_o", x_o, '0);
        check("rst_w_o", w_o, '0);
        check("rst_b_o", b_o, '0);
        check("rst_out_y", out_y, '0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Basic inference with a constant stub result, then 10 cycles of backpressure.
        stub_force = 1'b1;
        load_vec(basic);
        check("basic_x_o", x_o, basic.x);
        check("basic_w_o", w_o, basic.w);
        check("basic_b_o", b_o, basic.b);
        wait_result(n);
        check("basic_latency", n, 3);
        check("basic_out_y", out_y, DW'(8'h2A));
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!out_valid || out_y !== DW'(8'h2A) || in_ready) seen = 1'b1;
        end
        check("bp_stable", seen, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_valid_clear", out_valid, 1'b0);
        check("bp_in_ready", in_ready, 1'b1);
        stub_force = 1'b0;

        // Early last on element beat 1.
`ifdef PERCEPTRON_DRIVER_BIAS_EN
        beat(DW'(1), DW'(0), 1'b0);
`endif
        beat(DW'(9), DW'(9), 1'b0);
        beat(DW'(9), DW'(9), 1'b1);
        pulses = int'(err_len);
        seen = out_valid;
        for (int i = 0; i < 5; i++) begin
            step();
            pulses += int'(err_len);
            if (out_valid) seen = 1'b1;
        end
        check("early_err_pulses", pulses, 1);
        check("early_no_valid", seen, 1'b0);
        check("early_in_ready", in_ready, 1'b1);
        run_vec(tab[0], "after_early");

        // Missing last: full-length vector with in_last never set.
`ifdef PERCEPTRON_DRIVER_BIAS_EN
        beat(DW'(1), DW'(0), 1'b0);
`endif
        for (int i = 0; i < NN; i++) begin
            beat(DW'(i), DW'(i), 1'b0);
        end
        check("missing_err", err_len, 1'b1);
        check("missing_in_ready", in_ready, 1'b1);
        step();
        check("missing_err_clear", err_len, 1'b0);
        run_vec(tab[1], "after_missing");

`ifdef PERCEPTRON_DRIVER_BIAS_EN
        // Bias beat carrying in_last.
        beat(DW'(-3), DW'(0), 1'b1);
        check("bias_last_err", err_len, 1'b1);
        check("bias_last_in_ready", in_ready, 1'b1);
        step();
        run_vec(tab[0], "after_bias_err");
`endif

        // Reset asserted during WAIT.
        load_vec(tab[2]);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_x_o", x_o, '0);
        check("midrst_w_o", w_o, '0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", seen, 1'b0);

        // Table of directed and random vectors.
        for (int k = 0; k < NRV; k++) begin
            run_vec(tab[k], $sformatf("vec%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/perceptron_driver.md
# perceptron_driver

Streaming front end for the Perceptron datapath. It accepts input/weight element pairs one beat at a time over a valid/ready handshake and assembles them into the packed x/w vectors and bias that the Perceptron consumes. It holds those vectors stable for the Perceptron's pipeline latency, captures the activated result, and returns it on a valid/ready result port. It sits between the NPU's element stream (memory/DMA side) and one Perceptron instance.

## Interface
- N, default `N: vector length (elements per inference)
- DATA_WIDTH, default `DATA_WIDTH: element, bias and result width (signed)
- LATENCY, default 2: Perceptron clock edges from an x/w/b change to the matching y
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  element beat valid
- in_ready  out  1  driver can accept a beat
- in_x  in  DATA_WIDTH  input element (bias on the bias beat)
- in_w  in  DATA_WIDTH  weight element (ignored on the bias beat)
- in_last  in  1  final beat of the vector
- x_o  out  N*DATA_WIDTH  packed inputs to Perceptron; element i at [i*DATA_WIDTH +: DATA_WIDTH]
- w_o  out  N*DATA_WIDTH  packed weights to Perceptron; same packing as x_o
- b_o  out  DATA_WIDTH  bias to Perceptron
- y_i  in  DATA_WIDTH  Perceptron activated output
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- out_y  out  DATA_WIDTH  captured result
- err_len  out  1  one-cycle pulse on a vector-length mismatch

## Operation
- Reset values:
  - state LOAD; beat counter 0.
  - x_o, w_o, b_o, out_y all 0.
  - in_ready 1; out_valid 0; err_len 0.
- FSM states: LOAD → WAIT → RESULT → LOAD.
- LOAD:
  - in_ready = 1.
  - A beat is accepted when in_valid && in_ready.
  - Accepted beat k (0-based, after any bias beat) writes element slot k of x_o and w_o directly, so vector registers update beat by beat.
  - Counter increments per accepted beat.
- Final beat: the accepted beat with k == N-1.
  - If in_last == 1: go to WAIT, clear the wait counter.
  - If in_last == 0: pulse err_len, clear the counter, stay in LOAD. Vector contents are don't-care until rewritten.
- Early last: a beat with in_last == 1 and k < N-1 pulses err_len, clears the counter, stays in LOAD.
- WAIT:
  - in_ready = 0; x_o, w_o, b_o held stable.
  - The wait counter counts LATENCY edges.
  - On the next edge after that, y_i is captured into out_y, out_valid is set, and the FSM goes to RESULT.
- RESULT:
  - in_ready = 0; out_valid = 1; out_y stable.
  - On out_valid && out_ready: out_valid clears, the counter clears, and the FSM returns to LOAD.
  - x_o and w_o keep their old values until overwritten.
- Arithmetic:
  - The driver performs no arithmetic on data; values pass through bit-exact.
  - Counters are $clog2(N+1) and $clog2(LATENCY+1) bits wide.
- Reset asserted in any state forces all reset values immediately. A partially loaded vector or pending result is dropped.

## Timing
- The final beat is accepted at edge E0. x_o/w_o carry the full vector after E0.
- y_i reflects that vector after E0+LATENCY. It is captured at E0+LATENCY+1, and out_valid is high from there.
- With LATENCY = 2, out_valid rises 3 cycles after the final beat.
- Throughput: one vector per N(+1) + LATENCY + 2 cycles when out_ready is held high.
- in_ready is combinational from state only, never from in_valid.
- out_valid/out_y are registered; once raised, they hold until the handshake.
- err_len is registered, one cycle wide, and asserts the cycle after the offending beat.

## Configuration
- PERCEPTRON_DRIVER_BIAS_EN defined:
  - Each vector is N+1 beats. Beat 0 is the bias: in_x → b_o, in_w ignored, in_last must be 0.
  - A bias beat with in_last == 1 pulses err_len and restarts.
  - The element beats follow with k = 0..N-1.
- Not defined:
  - b_o is tied to 0 and each vector is N beats.
- The Timing rules are unchanged; E0 is always the last element beat.

## Structure
- Shared package npu_pkg holds:
  - the state typedef enum {LOAD, WAIT, RESULT};
  - the localparam PERCEPTRON_LATENCY = 2, used as the LATENCY default.
- One sub-module, vector_packer:
  - holds the N-slot x/w register file with a write enable and index, plus the bias register;
  - the FSM, counters and handshake live in perceptron_driver.

## Test plan
- Basic inference (N=4, DATA_WIDTH=8, LATENCY=2, no bias). Stimulus: beats x={1,2,3,4}, w={5,6,7,8}, last on beat 3; the bench's 2-stage stub drives y_i=8'h2A. Required: x_o=32'h04030201, w_o=32'h08070605, out_valid rises 3 cycles after E0, out_y=8'h2A.
- Result backpressure: out_ready held 0 for 10 cycles. Required: out_valid and out_y stay stable, in_ready stays 0; handshake on cycle 11 returns to LOAD with in_ready=1.
- Early last: in_last on beat 1. Required: err_len pulses once, no out_valid; the next 4 correct beats produce a normal result.
- Missing last: 4 beats with in_last=0. Required: err_len pulses, state stays LOAD, counter is 0.
- Bias (PERCEPTRON_DRIVER_BIAS_EN): bias beat in_x=-3, then 4 element beats. Required: b_o=8'hFD while in WAIT; a bias beat carrying in_last raises err_len.
- Reset mid-operation: assert rst during WAIT. Required: outputs go to reset values asynchronously, no out_valid after release, a new vector completes normally.
